// File: rtl/mem_arb_pkg.sv
// Shared types and geometry for the cache-line to burst-memory arbiter.
package mem_arb_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int OFFSET_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_BURST,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

  // Clear the byte-offset bits so the burst starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~((32'd1 << OFFSET_W) - 32'd1);
  endfunction

endpackage

// File: rtl/cacheline_mem_arbiter_if.sv
// Bundles both cache dfp ports and the burst memory port.
// master: caches plus memory (environment side); slave: the arbiter.
interface cacheline_mem_arbiter_if;
  import mem_arb_pkg::*;

  logic [31:0]       i_dfp_addr;
  logic              i_dfp_read;
  logic              i_dfp_write;
  logic [LINE_W-1:0] i_dfp_wdata;
  logic [LINE_W-1:0] i_dfp_rdata;
  logic              i_dfp_resp;
  logic              i_in_arbit;

  logic [31:0]       d_dfp_addr;
  logic              d_dfp_read;
  logic              d_dfp_write;
  logic [LINE_W-1:0] d_dfp_wdata;
  logic [LINE_W-1:0] d_dfp_rdata;
  logic              d_dfp_resp;
  logic              d_in_arbit;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    output i_dfp_addr, i_dfp_read, i_dfp_write, i_dfp_wdata,
    input  i_dfp_rdata, i_dfp_resp, i_in_arbit,
    output d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
    input  d_dfp_rdata, d_dfp_resp, d_in_arbit,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  i_dfp_addr, i_dfp_read, i_dfp_write, i_dfp_wdata,
    output i_dfp_rdata, i_dfp_resp, i_in_arbit,
    input  d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
    output d_dfp_rdata, d_dfp_resp, d_in_arbit,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

endinterface

// File: rtl/line_beat_buffer.sv
// One cache line with beat-indexed load/extract and a beat counter.
// Holds writeback data for serialisation and assembles read beats.
module line_beat_buffer
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_line,
  input  logic [LINE_W-1:0] line_in,
  input  logic              store_beat,
  input  logic [BEAT_W-1:0] beat_in,
  input  logic              advance,
  input  logic              clear,
  output logic [LINE_W-1:0] line_out,
  output logic [BEAT_W-1:0] beat_out,
  output logic              last_beat
);

  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  beat_idx;

  // Beat counter: steps on each stored or accepted beat, cleared per transaction.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      beat_idx <= '0;
    end else if (clear) begin
      beat_idx <= '0;
    end else if (store_beat || advance) begin
      beat_idx <= beat_idx + CNT_W'(1);
    end
  end

  // Line storage: whole-line load at grant, single-beat store on read data.
  // NOTE: the line register is pure datapath with no reset; every consumer is
  // gated by FSM state, so its contents are never visible before being written.
  always_ff @(posedge clk) begin
    if (load_line) begin
      line_q <= line_in;
    end else if (store_beat) begin
      line_q[beat_idx*BEAT_W +: BEAT_W] <= beat_in;
    end
  end

  assign line_out  = line_q;
  assign beat_out  = line_q[beat_idx*BEAT_W +: BEAT_W];
  assign last_beat = (beat_idx == CNT_W'(BEATS - 1));

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates icache/dcache line requests onto one burst memory port.
// Round-robin on contention; reads deserialised, writebacks serialised.
module cacheline_mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  cacheline_mem_arbiter_if.slave bus
);

  arb_state_t        state, next_state;
  arb_port_t         grant_port, last_grant, grant_sel;
  arb_op_t           op;
  logic [31:0]       addr_q;

  logic              i_req, d_req;
  logic              sel_write;
  logic [31:0]       sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  logic              grant_en, buf_store, buf_adv, buf_clear;
  logic [LINE_W-1:0] buf_line;
  logic [BEAT_W-1:0] buf_beat;
  logic              last_beat;
  logic              beat_match;

  logic [LINE_W-1:0] resp_line, i_rdata_q, d_rdata_q;
  logic              i_resp, d_resp;

  assign i_req = bus.i_dfp_read | bus.i_dfp_write;
  assign d_req = bus.d_dfp_read | bus.d_dfp_write;

  // Round-robin pick: on contention take the port not served last time.
  always_comb begin
    grant_sel = PORT_I;
    if (i_req && d_req) begin
      if (last_grant == PORT_I) begin
        grant_sel = PORT_D;
      end
    end else if (d_req) begin
      grant_sel = PORT_D;
    end
  end

  // Write wins when a port raises read and write together.
  assign sel_write  = (grant_sel == PORT_D) ? bus.d_dfp_write : bus.i_dfp_write;
  assign sel_addr   = (grant_sel == PORT_D) ? bus.d_dfp_addr  : bus.i_dfp_addr;
  assign sel_wdata  = (grant_sel == PORT_D) ? bus.d_dfp_wdata : bus.i_dfp_wdata;

  assign beat_match = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);

  // State register; async reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and memory-side command outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    next_state      = state;
    grant_en        = 1'b0;
    buf_store       = 1'b0;
    buf_adv         = 1'b0;
    buf_clear       = 1'b0;
    bus.bmem_addr   = '0;
    bus.bmem_read   = 1'b0;
    bus.bmem_write  = 1'b0;
    bus.bmem_wdata  = '0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_en = 1'b1;
          if (sel_write) begin
            next_state = WR_BURST;
          end else begin
            next_state = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        bus.bmem_read = 1'b1;
        bus.bmem_addr = addr_q;
        if (bus.bmem_ready) begin
          next_state = RD_DATA;
        end
      end
      RD_DATA: begin
        if (beat_match) begin
          buf_store = 1'b1;
          if (last_beat) begin
            next_state = RESP;
          end
        end
      end
      WR_BURST: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = addr_q;
        bus.bmem_wdata = buf_beat;
        if (bus.bmem_ready) begin
          buf_adv = 1'b1;
          if (last_beat) begin
            next_state = RESP;
          end
        end
      end
      RESP: begin
        buf_clear  = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latch the granted request; it runs to completion even if the cache drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_port <= PORT_I;
      last_grant <= PORT_I;
      op         <= OP_READ;
      addr_q     <= '0;
    end else begin
      if (grant_en) begin
        grant_port <= grant_sel;
        addr_q     <= line_align(sel_addr);
        if (sel_write) begin
          op <= OP_WRITE;
        end else begin
          op <= OP_READ;
        end
      end
      if (state == RESP) begin
        last_grant <= grant_port;
      end
    end
  end

  line_beat_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .load_line  (grant_en),
    .line_in    (sel_wdata),
    .store_beat (buf_store),
    .beat_in    (bus.bmem_rdata),
    .advance    (buf_adv),
    .clear      (buf_clear),
    .line_out   (buf_line),
    .beat_out   (buf_beat),
    .last_beat  (last_beat)
  );

  assign resp_line = (op == OP_READ) ? buf_line : '0;
  assign i_resp    = (state == RESP) && (grant_port == PORT_I);
  assign d_resp    = (state == RESP) && (grant_port == PORT_D);

  // Per-port copy of the returned line so it survives the other port's traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_resp) begin
        i_rdata_q <= resp_line;
      end
      if (d_resp) begin
        d_rdata_q <= resp_line;
      end
    end
  end

  assign bus.i_dfp_resp  = i_resp;
  assign bus.d_dfp_resp  = d_resp;
  assign bus.i_dfp_rdata = i_resp ? resp_line : i_rdata_q;
  assign bus.d_dfp_rdata = d_resp ? resp_line : d_rdata_q;
  assign bus.i_in_arbit  = (state != IDLE) && (grant_port == PORT_I);
  assign bus.d_in_arbit  = (state != IDLE) && (grant_port == PORT_D);

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter: cycle-exact scenarios with
// hand-computed expected lines, beats and handshake outputs.
module tb_cacheline_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  cacheline_mem_arbiter_if bus ();

  cacheline_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] ra, input logic [63:0] d);
    bus.bmem_rvalid = 1'b1;
    bus.bmem_raddr  = ra;
    bus.bmem_rdata  = d;
    tick();
  endtask

  task automatic idle_inputs();
    bus.i_dfp_addr  = '0; bus.i_dfp_read = 1'b0; bus.i_dfp_write = 1'b0; bus.i_dfp_wdata = '0;
    bus.d_dfp_addr  = '0; bus.d_dfp_read = 1'b0; bus.d_dfp_write = 1'b0; bus.d_dfp_wdata = '0;
    bus.bmem_ready  = 1'b0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if ({bus.bmem_read, bus.bmem_write, bus.bmem_addr, bus.bmem_wdata} !== 98'd0) begin n_bad++; $display("FAIL reset_bmem: got %h want 0", {bus.bmem_read, bus.bmem_write, bus.bmem_addr, bus.bmem_wdata}); end
    n_cmp++; if ({bus.i_dfp_resp, bus.i_in_arbit, bus.d_dfp_resp, bus.d_in_arbit} !== 4'b0000) begin n_bad++; $display("FAIL reset_dfp_ctrl: got %b want 0000", {bus.i_dfp_resp, bus.i_in_arbit, bus.d_dfp_resp, bus.d_in_arbit}); end
    n_cmp++; if ((bus.i_dfp_rdata | bus.d_dfp_rdata) !== 256'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.i_dfp_rdata | bus.d_dfp_rdata); end
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.bmem_read !== 1'b0) begin n_bad++; $display("FAIL idle_no_req: got %b want 0", bus.bmem_read); end
  endtask

  task automatic test_icache_read();
    logic [255:0] exp_line;
    exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    bus.i_dfp_addr = 32'h0000_1024; bus.i_dfp_read = 1'b1; bus.bmem_ready = 1'b1;
    tick();
    n_cmp++; if ({bus.bmem_read, bus.bmem_addr} !== {1'b1, 32'h0000_1020}) begin n_bad++; $display("FAIL ird_cmd: got %b/%h want 1/00001020", bus.bmem_read, bus.bmem_addr); end
    n_cmp++; if ({bus.i_in_arbit, bus.d_in_arbit} !== 2'b10) begin n_bad++; $display("FAIL ird_arbit: got %b want 10", {bus.i_in_arbit, bus.d_in_arbit}); end
    tick();
    n_cmp++; if ({bus.bmem_read, bus.i_in_arbit} !== 2'b01) begin n_bad++; $display("FAIL ird_data_state: got %b want 01", {bus.bmem_read, bus.i_in_arbit}); end
    beat(32'h0000_1020, 64'h1111_1111_1111_1111);
    beat(32'h0000_1020, 64'h2222_2222_2222_2222);
    beat(32'h0000_1020, 64'h3333_3333_3333_3333);
    n_cmp++; if (bus.i_dfp_resp !== 1'b0) begin n_bad++; $display("FAIL ird_early_resp: got %b want 0", bus.i_dfp_resp); end
    beat(32'h0000_1020, 64'h4444_4444_4444_4444);
    bus.bmem_rvalid = 1'b0; bus.i_dfp_read = 1'b0;
    n_cmp++; if ({bus.i_dfp_resp, bus.d_dfp_resp, bus.i_in_arbit} !== 3'b101) begin n_bad++; $display("FAIL ird_resp: got %b want 101", {bus.i_dfp_resp, bus.d_dfp_resp, bus.i_in_arbit}); end
    n_cmp++; if (bus.i_dfp_rdata !== exp_line) begin n_bad++; $display("FAIL ird_line: got %h want %h", bus.i_dfp_rdata, exp_line); end
    tick();
    n_cmp++; if ({bus.i_dfp_resp, bus.i_in_arbit} !== 2'b00) begin n_bad++; $display("FAIL ird_after: got %b want 00", {bus.i_dfp_resp, bus.i_in_arbit}); end
    n_cmp++; if (bus.i_dfp_rdata !== exp_line) begin n_bad++; $display("FAIL ird_hold: got %h want %h", bus.i_dfp_rdata, exp_line); end
  endtask

  task automatic test_arbitration();
    logic [255:0] exp_d, exp_i;
    exp_d = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002, 64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
    exp_i = {64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002, 64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000};
    bus.i_dfp_addr = 32'h0000_1100; bus.i_dfp_read = 1'b1;
    bus.d_dfp_addr = 32'h0000_2200; bus.d_dfp_read = 1'b1;
    bus.bmem_ready = 1'b1;
    tick();
    n_cmp++; if ({bus.d_in_arbit, bus.i_in_arbit} !== 2'b10) begin n_bad++; $display("FAIL arb_first_d: got %b want 10", {bus.d_in_arbit, bus.i_in_arbit}); end
    n_cmp++; if (bus.bmem_addr !== 32'h0000_2200) begin n_bad++; $display("FAIL arb_d_addr: got %h want 00002200", bus.bmem_addr); end
    tick();
    for (int k = 0; k < 4; k++) beat(32'h0000_2200, exp_d[k*64 +: 64]);
    bus.bmem_rvalid = 1'b0; bus.d_dfp_read = 1'b0;
    n_cmp++; if ({bus.d_dfp_resp, bus.i_dfp_resp, bus.i_in_arbit} !== 3'b100) begin n_bad++; $display("FAIL arb_d_resp: got %b want 100", {bus.d_dfp_resp, bus.i_dfp_resp, bus.i_in_arbit}); end
    n_cmp++; if (bus.d_dfp_rdata !== exp_d) begin n_bad++; $display("FAIL arb_d_line: got %h want %h", bus.d_dfp_rdata, exp_d); end
    tick();
    n_cmp++; if ({bus.d_in_arbit, bus.i_in_arbit, bus.bmem_read} !== 3'b000) begin n_bad++; $display("FAIL arb_gap: got %b want 000", {bus.d_in_arbit, bus.i_in_arbit, bus.bmem_read}); end
    tick();
    n_cmp++; if ({bus.d_in_arbit, bus.i_in_arbit, bus.bmem_addr} !== {2'b01, 32'h0000_1100}) begin n_bad++; $display("FAIL arb_second_i: got %b/%h want 01/00001100", {bus.d_in_arbit, bus.i_in_arbit}, bus.bmem_addr); end
    tick();
    for (int k = 0; k < 4; k++) beat(32'h0000_1100, exp_i[k*64 +: 64]);
    bus.bmem_rvalid = 1'b0; bus.i_dfp_read = 1'b0;
    n_cmp++; if ({bus.i_dfp_resp, bus.d_dfp_resp} !== 2'b10) begin n_bad++; $display("FAIL arb_i_resp: got %b want 10", {bus.i_dfp_resp, bus.d_dfp_resp}); end
    n_cmp++; if (bus.i_dfp_rdata !== exp_i) begin n_bad++; $display("FAIL arb_i_line: got %h want %h", bus.i_dfp_rdata, exp_i); end
    n_cmp++; if (bus.d_dfp_rdata !== exp_d) begin n_bad++; $display("FAIL arb_d_hold: got %h want %h", bus.d_dfp_rdata, exp_d); end
    tick();
  endtask

  task automatic test_dcache_write();
    logic [255:0] wline;
    wline = {64'hAAAA_AAAA_AAAA_AAA3, 64'hAAAA_AAAA_AAAA_AAA2, 64'hAAAA_AAAA_AAAA_AAA1, 64'hAAAA_AAAA_AAAA_AAA0};
    bus.d_dfp_addr = 32'h0000_2040; bus.d_dfp_write = 1'b1; bus.d_dfp_read = 1'b1;
    bus.d_dfp_wdata = wline; bus.bmem_ready = 1'b1;
    tick();
    n_cmp++; if ({bus.bmem_write, bus.bmem_read, bus.bmem_addr} !== {2'b10, 32'h0000_2040}) begin n_bad++; $display("FAIL wr_cmd: got %b%b/%h want 10/00002040", bus.bmem_write, bus.bmem_read, bus.bmem_addr); end
    n_cmp++; if (bus.bmem_wdata !== wline[63:0]) begin n_bad++; $display("FAIL wr_beat0: got %h want %h", bus.bmem_wdata, wline[63:0]); end
    tick();
    n_cmp++; if (bus.bmem_wdata !== wline[127:64]) begin n_bad++; $display("FAIL wr_beat1: got %h want %h", bus.bmem_wdata, wline[127:64]); end
    tick();
    bus.bmem_ready = 1'b0;
    n_cmp++; if (bus.bmem_wdata !== wline[191:128]) begin n_bad++; $display("FAIL wr_beat2: got %h want %h", bus.bmem_wdata, wline[191:128]); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if ({bus.bmem_write, bus.bmem_wdata} !== {1'b1, wline[191:128]}) begin n_bad++; $display("FAIL wr_beat2_stall%0d: got %b/%h want 1/%h", c, bus.bmem_write, bus.bmem_wdata, wline[191:128]); end
    end
    bus.bmem_ready = 1'b1;
    tick();
    n_cmp++; if (bus.bmem_wdata !== wline[255:192]) begin n_bad++; $display("FAIL wr_beat3: got %h want %h", bus.bmem_wdata, wline[255:192]); end
    n_cmp++; if (bus.d_dfp_resp !== 1'b0) begin n_bad++; $display("FAIL wr_early_resp: got %b want 0", bus.d_dfp_resp); end
    tick();
    bus.d_dfp_write = 1'b0; bus.d_dfp_read = 1'b0;
    n_cmp++; if ({bus.d_dfp_resp, bus.i_dfp_resp, bus.bmem_write} !== 3'b100) begin n_bad++; $display("FAIL wr_resp: got %b want 100", {bus.d_dfp_resp, bus.i_dfp_resp, bus.bmem_write}); end
    n_cmp++; if (bus.d_dfp_rdata !== 256'd0) begin n_bad++; $display("FAIL wr_rdata_zero: got %h want 0", bus.d_dfp_rdata); end
    tick();
    n_cmp++; if ({bus.d_dfp_resp, bus.d_in_arbit} !== 2'b00) begin n_bad++; $display("FAIL wr_after: got %b want 00", {bus.d_dfp_resp, bus.d_in_arbit}); end
  endtask

  task automatic test_flush();
    logic [255:0] exp_line;
    exp_line = {64'hF3F3_F3F3_0000_0003, 64'hF2F2_F2F2_0000_0002, 64'hF1F1_F1F1_0000_0001, 64'hF0F0_F0F0_0000_0000};
    bus.i_dfp_addr = 32'h0000_1020; bus.i_dfp_read = 1'b1; bus.bmem_ready = 1'b1;
    tick();
    tick();
    beat(32'h0000_1020, exp_line[63:0]);
    beat(32'h0000_1020, exp_line[127:64]);
    bus.i_dfp_read = 1'b0;
    beat(32'h0000_1020, exp_line[191:128]);
    beat(32'h0000_1020, exp_line[255:192]);
    bus.bmem_rvalid = 1'b0;
    n_cmp++; if ({bus.i_dfp_resp, bus.i_in_arbit} !== 2'b11) begin n_bad++; $display("FAIL flush_resp: got %b want 11", {bus.i_dfp_resp, bus.i_in_arbit}); end
    n_cmp++; if (bus.i_dfp_rdata !== exp_line) begin n_bad++; $display("FAIL flush_line: got %h want %h", bus.i_dfp_rdata, exp_line); end
    tick();
    n_cmp++; if ({bus.i_dfp_resp, bus.i_in_arbit} !== 2'b00) begin n_bad++; $display("FAIL flush_after: got %b want 00", {bus.i_dfp_resp, bus.i_in_arbit}); end
    tick();
    n_cmp++; if ({bus.i_dfp_resp, bus.i_in_arbit, bus.bmem_read} !== 3'b000) begin n_bad++; $display("FAIL flush_idle: got %b want 000", {bus.i_dfp_resp, bus.i_in_arbit, bus.bmem_read}); end
  endtask

  task automatic test_mismatch();
    logic [255:0] exp_line;
    exp_line = {64'h0D0D_0000_0000_0003, 64'h0C0C_0000_0000_0002, 64'h0B0B_0000_0000_0001, 64'h0A0A_0000_0000_0000};
    bus.i_dfp_addr = 32'h0000_103F; bus.i_dfp_read = 1'b1; bus.bmem_ready = 1'b0;
    tick();
    n_cmp++; if ({bus.bmem_read, bus.bmem_addr} !== {1'b1, 32'h0000_1020}) begin n_bad++; $display("FAIL mm_cmd: got %b/%h want 1/00001020", bus.bmem_read, bus.bmem_addr); end
    bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'h0000_1020; bus.bmem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    n_cmp++; if ({bus.bmem_read, bus.bmem_addr} !== {1'b1, 32'h0000_1020}) begin n_bad++; $display("FAIL mm_cmd_held: got %b/%h want 1/00001020", bus.bmem_read, bus.bmem_addr); end
    bus.bmem_ready = 1'b1;
    tick();
    beat(32'h0000_1020, exp_line[63:0]);
    beat(32'h0000_3000, 64'hBAD0_BAD0_BAD0_BAD0);
    beat(32'h0000_1020, exp_line[127:64]);
    bus.bmem_rvalid = 1'b0;
    tick();
    beat(32'h0000_1020, exp_line[191:128]);
    beat(32'h0000_3000, 64'hBAD1_BAD1_BAD1_BAD1);
    n_cmp++; if (bus.i_dfp_resp !== 1'b0) begin n_bad++; $display("FAIL mm_early_resp: got %b want 0", bus.i_dfp_resp); end
    beat(32'h0000_1020, exp_line[255:192]);
    bus.bmem_rvalid = 1'b0; bus.i_dfp_read = 1'b0;
    n_cmp++; if (bus.i_dfp_resp !== 1'b1) begin n_bad++; $display("FAIL mm_resp: got %b want 1", bus.i_dfp_resp); end
    n_cmp++; if (bus.i_dfp_rdata !== exp_line) begin n_bad++; $display("FAIL mm_line: got %h want %h", bus.i_dfp_rdata, exp_line); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    logic [255:0] wline;
    wline = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
    bus.d_dfp_addr = 32'h0000_2040; bus.d_dfp_write = 1'b1; bus.d_dfp_wdata = wline; bus.bmem_ready = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++; if (bus.bmem_wdata !== wline[191:128]) begin n_bad++; $display("FAIL rstw_pre: got %h want %h", bus.bmem_wdata, wline[191:128]); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.bmem_write, bus.bmem_read, bus.bmem_addr, bus.bmem_wdata} !== 98'd0) begin n_bad++; $display("FAIL rstw_bmem: got %h want 0", {bus.bmem_write, bus.bmem_read, bus.bmem_addr, bus.bmem_wdata}); end
    n_cmp++; if ({bus.d_in_arbit, bus.d_dfp_resp, bus.i_in_arbit, bus.i_dfp_resp} !== 4'b0000) begin n_bad++; $display("FAIL rstw_ctrl: got %b want 0000", {bus.d_in_arbit, bus.d_dfp_resp, bus.i_in_arbit, bus.i_dfp_resp}); end
    n_cmp++; if ((bus.i_dfp_rdata | bus.d_dfp_rdata) !== 256'd0) begin n_bad++; $display("FAIL rstw_rdata: got %h want 0", bus.i_dfp_rdata | bus.d_dfp_rdata); end
    #2 rst = 1'b0;
    tick();
    n_cmp++; if ({bus.bmem_write, bus.bmem_addr, bus.bmem_wdata} !== {1'b1, 32'h0000_2040, wline[63:0]}) begin n_bad++; $display("FAIL rstw_restart: got %b/%h/%h want 1/00002040/%h", bus.bmem_write, bus.bmem_addr, bus.bmem_wdata, wline[63:0]); end
    for (int k = 1; k < 4; k++) begin
      tick();
      n_cmp++; if (bus.bmem_wdata !== wline[k*64 +: 64]) begin n_bad++; $display("FAIL rstw_beat%0d: got %h want %h", k, bus.bmem_wdata, wline[k*64 +: 64]); end
    end
    tick();
    bus.d_dfp_write = 1'b0;
    n_cmp++; if (bus.d_dfp_resp !== 1'b1) begin n_bad++; $display("FAIL rstw_resp: got %b want 1", bus.d_dfp_resp); end
    tick();
    n_cmp++; if ({bus.d_dfp_resp, bus.d_in_arbit, bus.bmem_write} !== 3'b000) begin n_bad++; $display("FAIL rstw_after: got %b want 000", {bus.d_dfp_resp, bus.d_in_arbit, bus.bmem_write}); end
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_arbitration();
    test_dcache_write();
    test_flush();
    test_mismatch();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cacheline_mem_arbiter.md
Name: cacheline_mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and data cache `dfp` ports.
- Arbitrates the two 256-bit line requests onto one burst memory port (64-bit beats, 4 beats per line).
- Deserialises read bursts into a line; serialises writebacks into beats.
- Drives `in_arbit` so each cache knows whether its outstanding `dfp` request is the one being serviced.

Parameters:
- LINE_W, 256, cache line width in bits
- BEAT_W, 64, memory beat width in bits
- BEATS, 4, beats per line (LINE_W/BEAT_W)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_dfp_addr  in  32  icache line address
- i_dfp_read  in  1  icache line read request
- i_dfp_write  in  1  icache line write request (never asserted by icache; still serviced)
- i_dfp_wdata  in  256  icache writeback line
- i_dfp_rdata  out  256  line returned to icache
- i_dfp_resp  out  1  one-cycle completion pulse to icache
- i_in_arbit  out  1  icache transaction granted and in flight
- d_dfp_addr / d_dfp_read / d_dfp_write / d_dfp_wdata  in  32/1/1/256  dcache request, same meaning
- d_dfp_rdata  out  256  line to dcache
- d_dfp_resp  out  1  completion pulse to dcache
- d_in_arbit  out  1  dcache transaction granted
- bmem_addr  out  32  burst address, line aligned
- bmem_read  out  1  read command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat
- bmem_ready  in  1  memory accepts command/beat this cycle
- bmem_raddr  in  32  address tag of returning read beat
- bmem_rdata  in  64  read beat
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (async): state=IDLE, grant cleared, beat counter=0, last_grant=I; all outputs 0.
- State machine: IDLE, RD_REQ, RD_DATA, WR_BURST, RESP.
- IDLE arbitration:
  - A port requests when read|write is high.
  - If both ports request, grant the port not granted last (round-robin); a single requester is always granted.
  - On grant, register: port, `{addr[31:5], 5'b0}`, op, wdata.
  - Next state: RD_REQ (read) or WR_BURST (write).
  - If read and write are both high on one port, write wins.
- `in_arbit` of the granted port is 1 from the cycle after grant through the RESP cycle inclusive; it is 0 otherwise and in IDLE.
- The latched request completes even if the cache drops read/write mid-transaction (branch flush). The cache discards the result itself.
- RD_REQ:
  - bmem_read=1 and bmem_addr=latched addr, held until bmem_ready.
  - Go to RD_DATA the cycle after bmem_ready is sampled high.
- RD_DATA:
  - Each cycle with bmem_rvalid && bmem_raddr==latched addr, store bmem_rdata into line bits [64k+63:64k], where k is the beat counter, then increment k.
  - Beats with a mismatched raddr are dropped.
  - After beat k=3 is stored, go to RESP.
- WR_BURST:
  - bmem_write=1, bmem_addr=latched addr, bmem_wdata=wdata[64k+:64].
  - k advances only on bmem_ready.
  - After beat 3 is accepted, go to RESP.
  - No memory acknowledge is awaited.
- RESP (one cycle):
  - Granted port's dfp_resp=1; its dfp_rdata = assembled line (reads) or 0 (writes).
  - Record last_grant, clear k, go to IDLE.
  - The other port's resp stays 0.
- dfp_rdata of the granted port holds the assembled line from RESP until the next grant to that port.
- Requests still high during RESP are not regranted that cycle. Arbitration resumes in IDLE next cycle (minimum 1 idle cycle between transactions).
- Read latency with zero-wait memory: grant cycle + 1 RD_REQ + 4 beats + 1 RESP.
- Reset mid-burst: abort immediately. Read beats arriving in IDLE are ignored. A partial write is not replayed.
- rvalid outside RD_DATA is ignored.
- bmem_ready low in RD_DATA has no effect.

Decomposition:
- Shared package `mem_arb_pkg`: enum `arb_state_t` {IDLE, RD_REQ, RD_DATA, WR_BURST, RESP}; enum `arb_port_t` {PORT_I, PORT_D}; constants LINE_W, BEAT_W, BEATS.
- One sub-module is natural: `line_beat_buffer`, a 256-bit line register with beat-indexed load/extract and a 2-bit beat counter. It is shared by the read and write paths.

Test Plan:
- icache read 0x0000_1024, memory returns beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles.
  -> bmem_addr=0x0000_1020; i_dfp_rdata={0x44..,0x33..,0x22..,0x11..}; one-cycle i_dfp_resp; i_in_arbit high throughout; d_dfp_resp=0.
- dcache writeback of line 0xAAAA...(beats A0..A3) to 0x0000_2040 with bmem_ready low for 2 cycles before beat 2.
  -> 4 bmem_write beats in order A0..A3, beat 2 held stable; d_dfp_resp one cycle after beat 3 is accepted.
- Both caches request reads in the same cycle, last_grant=I.
  -> dcache served first; icache served next, with at least 1 idle cycle between; no overlap of in_arbit.
- icache drops i_dfp_read two cycles into RD_DATA.
  -> burst still completes; i_dfp_resp pulses once; then IDLE.
- Mismatched beat (raddr=0x0000_3000) interleaved during a read of 0x0000_1020.
  -> beat ignored; line assembled only from matching beats.
- rst asserted mid-WR_BURST after beat 1.
  -> all outputs 0 immediately (async); state IDLE; next request is serviced from beat 0.
